// File: rtl/cic_readout_arbiter_if.sv
// rtl/cic_readout_arbiter_if.sv - sample-in / tagged-stream-out bundle for cic_readout_arbiter (dout_ts under CIC_ARB_TIMESTAMP_EN)
interface cic_readout_arbiter_if #(
    parameter int N_CH        = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int CH_ID_WIDTH = 2,
    parameter int TS_WIDTH    = 32
);
    logic [N_CH*DATA_WIDTH-1:0] din;
    logic [N_CH-1:0]            din_flag;
    logic [DATA_WIDTH-1:0]      dout;
    logic [CH_ID_WIDTH-1:0]     dout_ch;
    logic                       dout_valid;
    logic                       dout_ready;
    logic [N_CH-1:0]            overflow;
    logic [N_CH-1:0]            ovf_clear;
`ifdef CIC_ARB_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]        dout_ts;
`endif

    // Decimator bank / downstream consumer side
    modport master (
        output din, din_flag, dout_ready, ovf_clear,
`ifdef CIC_ARB_TIMESTAMP_EN
        input  dout_ts,
`endif
        input  dout, dout_ch, dout_valid, overflow
    );

    // Arbiter side
    modport slave (
        input  din, din_flag, dout_ready, ovf_clear,
`ifdef CIC_ARB_TIMESTAMP_EN
        output dout_ts,
`endif
        output dout, dout_ch, dout_valid, overflow
    );
endinterface

// File: rtl/cic_readout_arbiter.sv
// rtl/cic_readout_arbiter.sv - per-channel sample holding + round-robin serialiser; optional timestamps via CIC_ARB_TIMESTAMP_EN
module cic_readout_arbiter #(
    parameter int N_CH        = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int CH_ID_WIDTH = 2,
    parameter int TS_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cic_readout_arbiter_if.slave  bus
);
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [PTR_W:0]   N_CH_W   = (PTR_W + 1)'(N_CH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_CH - 1);

    // A channel tag too narrow to name every channel is a build error
    generate
        if ((1 << CH_ID_WIDTH) < N_CH) begin : g_bad_ch_id_width
            $error("CH_ID_WIDTH too small for N_CH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0]  r_hold [N_CH];
    logic [N_CH-1:0]        r_pend;
    logic [N_CH-1:0]        r_ovf;
    logic [PTR_W-1:0]       r_ptr;
    logic [DATA_WIDTH-1:0]  r_dout;
    logic [CH_ID_WIDTH-1:0] r_dout_ch;
    logic                   r_dout_valid;

    logic                   w_fire;
    logic                   w_grant;
    logic [PTR_W-1:0]       w_grant_idx;
    logic [N_CH-1:0]        w_grant_vec;
    logic [N_CH-1:0]        w_ovf_set;
    logic [PTR_W:0]         w_sum;

    // Output register may be reloaded when empty or being drained this cycle
    assign w_fire = !r_dout_valid || bus.dout_ready;

    // First pending channel at or after the pointer, wrapping modulo N_CH
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(i);
            if (w_sum >= N_CH_W) begin
                w_sum = w_sum - N_CH_W;
            end
            if (!w_grant && r_pend[PTR_W'(w_sum)]) begin
                w_grant     = 1'b1;
                w_grant_idx = PTR_W'(w_sum);
            end
        end
    end

    // Per-channel grant strobe and overwrite-before-send detection
    always_comb begin
        w_grant_vec = '0;
        w_ovf_set   = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_grant_vec[k] = w_fire && w_grant && (w_grant_idx == PTR_W'(k));
            // A flag colliding with its own grant is not an overwrite: the old sample leaves now
            w_ovf_set[k]   = bus.din_flag[k] && r_pend[k] && !w_grant_vec[k];
        end
    end

    // Holding registers, pending bits and sticky overflow (new event beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                r_hold[k] <= '0;
            end
            r_pend <= '0;
            r_ovf  <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (bus.din_flag[k]) begin
                    r_hold[k] <= bus.din[k*DATA_WIDTH +: DATA_WIDTH];
                    r_pend[k] <= 1'b1;
                end else if (w_grant_vec[k]) begin
                    r_pend[k] <= 1'b0;
                end
            end
            r_ovf <= (r_ovf & ~bus.ovf_clear) | w_ovf_set;
        end
    end

    // Output stage and round-robin pointer; pointer moves only on a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_ch    <= '0;
            r_dout_valid <= 1'b0;
            r_ptr        <= '0;
        end else if (w_fire) begin
            if (w_grant) begin
                r_dout       <= r_hold[w_grant_idx];
                r_dout_ch    <= CH_ID_WIDTH'(w_grant_idx);
                r_dout_valid <= 1'b1;
                r_ptr        <= (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + 1'b1;
            end else begin
                r_dout_valid <= 1'b0;
            end
        end
    end

`ifdef CIC_ARB_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_ts_cnt;
    logic [TS_WIDTH-1:0] r_ts_hold [N_CH];
    logic [TS_WIDTH-1:0] r_dout_ts;

    // Free-running stamp, captured alongside each sample and forwarded with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_cnt  <= '0;
            r_dout_ts <= '0;
            for (int k = 0; k < N_CH; k++) begin
                r_ts_hold[k] <= '0;
            end
        end else begin
            r_ts_cnt <= r_ts_cnt + 1'b1;
            for (int k = 0; k < N_CH; k++) begin
                if (bus.din_flag[k]) begin
                    r_ts_hold[k] <= r_ts_cnt;
                end
            end
            if (w_fire && w_grant) begin
                r_dout_ts <= r_ts_hold[w_grant_idx];
            end
        end
    end

    assign bus.dout_ts = r_dout_ts;
`endif

    assign bus.dout       = r_dout;
    assign bus.dout_ch    = r_dout_ch;
    assign bus.dout_valid = r_dout_valid;
    assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_cic_readout_arbiter.sv
// tb/tb_cic_readout_arbiter.sv - scoreboard bench for cic_readout_arbiter
module tb_cic_readout_arbiter;
    localparam int N_CH = 4;
    localparam int DW   = 32;
    localparam int CHW  = 2;
    localparam int TSW  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cic_readout_arbiter_if #(.N_CH(N_CH), .DATA_WIDTH(DW), .CH_ID_WIDTH(CHW), .TS_WIDTH(TSW)) bus ();

    cic_readout_arbiter #(.N_CH(N_CH), .DATA_WIDTH(DW), .CH_ID_WIDTH(CHW), .TS_WIDTH(TSW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [CHW-1:0] ch;
        logic [DW-1:0]  data;
        bit             ts_chk;
        logic [TSW-1:0] ts;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int n_vec = 0;
    int n_err = 0;
    bit stall_prev = 0;
    logic [DW-1:0]  prev_d;
    logic [CHW-1:0] prev_ch;
    int tb_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [DW-1:0] d);
        exp_t x;
        x.ch = CHW'(ch);
        x.data = d;
        x.ts_chk = 1'b0;
        x.ts = '0;
        q.push_back(x);
    endtask

    task automatic flag(input int k, input logic [DW-1:0] v);
        bus.din[k*DW +: DW] = v;
        bus.din_flag[k] = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.din = '0;
        bus.din_flag = '0;
        bus.dout_ready = 1'b0;
        bus.ovf_clear = '0;
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_valid", 64'(bus.dout_valid), 0);
        chk("rst_dout", 64'(bus.dout), 0);
        chk("rst_ovf", 64'(bus.overflow), 0);
    endtask

    // Reference free-running count, reset with the design
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 0;
        else        tb_cnt <= tb_cnt + 1;
    end

    // Monitor: stall stability and in-order scoreboard on each accepted beat
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 64'(bus.dout_valid), 1);
                chk("stall_data", 64'(bus.dout), 64'(prev_d));
                chk("stall_ch", 64'(bus.dout_ch), 64'(prev_ch));
            end
            if (bus.dout_valid && bus.dout_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected actual ch=%0d data=%0h required none", bus.dout_ch, bus.dout);
                end else begin
                    e = q.pop_front();
                    chk("sb_ch", 64'(bus.dout_ch), 64'(e.ch));
                    chk("sb_data", 64'(bus.dout), 64'(e.data));
`ifdef CIC_ARB_TIMESTAMP_EN
                    if (e.ts_chk) chk("sb_ts", 64'(bus.dout_ts), 64'(e.ts));
`endif
                end
            end
            stall_prev = bus.dout_valid && !bus.dout_ready;
            prev_d = bus.dout;
            prev_ch = bus.dout_ch;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        bus.din = '0;
        bus.din_flag = '0;
        bus.dout_ready = 1'b0;
        bus.ovf_clear = '0;

        // Single sample: two-edge latency, one beat
        do_reset();
        bus.dout_ready = 1'b1;
        repeat (3) tick();
        push(1, 32'h0000_1234);
        flag(1, 32'h0000_1234);
        tick();
        bus.din_flag = '0;
        chk("lat_early_valid", 64'(bus.dout_valid), 0);
        tick();
        chk("lat_valid", 64'(bus.dout_valid), 1);
        chk("lat_dout", 64'(bus.dout), 64'h1234);
        chk("lat_ch", 64'(bus.dout_ch), 1);
        tick();
        chk("lat_valid_low", 64'(bus.dout_valid), 0);
        chk("drain_single", 64'(q.size()), 0);

        // Round robin from pointer 0, back-to-back
        do_reset();
        bus.dout_ready = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            push(k, DW'(k + 100));
            flag(k, DW'(k + 100));
        end
        tick();
        bus.din_flag = '0;
        tick();
        for (int k = 0; k < N_CH; k++) begin
            chk("rr_valid", 64'(bus.dout_valid), 1);
            chk("rr_ch", 64'(bus.dout_ch), 64'(k));
            chk("rr_dout", 64'(bus.dout), 64'(k + 100));
            tick();
        end
        chk("rr_valid_low", 64'(bus.dout_valid), 0);
        chk("rr_ovf", 64'(bus.overflow), 0);
        chk("drain_rr", 64'(q.size()), 0);

        // Backpressure: five stalled cycles, second sample right after release
        do_reset();
        push(1, 32'h11);
        push(3, 32'h33);
        flag(1, 32'h11);
        flag(3, 32'h33);
        tick();
        bus.din_flag = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_ch", 64'(bus.dout_ch), 1);
            chk("bp_hold_dout", 64'(bus.dout), 64'h11);
            tick();
        end
        bus.dout_ready = 1'b1;
        tick();
        chk("bp_second_ch", 64'(bus.dout_ch), 3);
        chk("bp_second_dout", 64'(bus.dout), 64'h33);
        chk("bp_second_valid", 64'(bus.dout_valid), 1);
        tick();
        chk("bp_valid_low", 64'(bus.dout_valid), 0);
        chk("drain_bp", 64'(q.size()), 0);

        // Overflow: overwrite while stalled, clear, then clear colliding with a new overwrite
        do_reset();
        push(0, 32'hAA);
        push(2, 32'h9);
        flag(0, 32'hAA);
        tick();
        bus.din_flag = '0;
        tick();
        flag(2, 32'h5);
        tick();
        flag(2, 32'h9);
        tick();
        bus.din_flag = '0;
        chk("ovf_set", 64'(bus.overflow), 64'h4);
        bus.ovf_clear = 4'b0100;
        tick();
        bus.ovf_clear = '0;
        chk("ovf_cleared", 64'(bus.overflow), 0);
        flag(2, 32'h9);
        bus.ovf_clear = 4'b0100;
        tick();
        bus.din_flag = '0;
        bus.ovf_clear = '0;
        chk("ovf_set_wins", 64'(bus.overflow), 64'h4);
        bus.dout_ready = 1'b1;
        tick();
        chk("ovf_release_dout", 64'(bus.dout), 64'h9);
        chk("ovf_release_ch", 64'(bus.dout_ch), 2);
        tick();
        chk("drain_ovf", 64'(q.size()), 0);

        // Grant/flag collision: old value leaves, new one follows, no overflow
        do_reset();
        bus.dout_ready = 1'b1;
        push(0, 32'h7);
        push(0, 32'h8);
        flag(0, 32'h7);
        tick();
        flag(0, 32'h8);
        tick();
        bus.din_flag = '0;
        chk("col_first", 64'(bus.dout), 64'h7);
        tick();
        chk("col_second", 64'(bus.dout), 64'h8);
        chk("col_ovf", 64'(bus.overflow), 0);
        tick();
        chk("col_valid_low", 64'(bus.dout_valid), 0);
        chk("drain_col", 64'(q.size()), 0);

        // Asynchronous reset mid-cycle with pending samples and a set overflow
        do_reset();
        flag(0, 32'h101);
        flag(1, 32'h102);
        flag(2, 32'h103);
        tick();
        bus.din_flag = '0;
        tick();
        flag(1, 32'h222);
        tick();
        bus.din_flag = '0;
        chk("ar_pre_valid", 64'(bus.dout_valid), 1);
        chk("ar_pre_ovf", 64'(bus.overflow), 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(bus.dout_valid), 0);
        chk("ar_dout", 64'(bus.dout), 0);
        chk("ar_ch", 64'(bus.dout_ch), 0);
        chk("ar_ovf", 64'(bus.overflow), 0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ar_no_stale", 64'(bus.dout_valid), 0);
        end

`ifdef CIC_ARB_TIMESTAMP_EN
        // Timestamp captured with the flag at count 20
        do_reset();
        bus.dout_ready = 1'b1;
        chk("ts_rst", 64'(bus.dout_ts), 0);
        while (tb_cnt < 20) tick();
        begin
            exp_t x;
            x.ch = 2'd3;
            x.data = 32'h77;
            x.ts_chk = 1'b1;
            x.ts = 32'd20;
            q.push_back(x);
        end
        flag(3, 32'h77);
        tick();
        bus.din_flag = '0;
        tick();
        chk("ts_value", 64'(bus.dout_ts), 20);
        tick();
        chk("drain_ts", 64'(q.size()), 0);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
